// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequencer for a bank of LANES MAC units fed from per-lane
// A-operand FIFOs and one shared B-operand FIFO.
//
// A job is CLEAR (one-cycle mac_clr), RUN (DEPTH lockstep reads across all
// lanes, stalling whenever any FIFO is empty), DRAIN (two cycles for the MAC
// multiply and accumulate registers), then DONE (one-cycle done pulse).
// With no stalls the done pulse arrives DEPTH+5 cycles after start is sampled.
//
// Optional feature, enabled by defining MAC_SEQ_CTRL_STALL_CNT_EN:
//   stall_cnt counts RUN cycles lost to empty FIFOs (saturating, cleared when
//   a new job is accepted). When the macro is undefined stall_cnt is tied to 0.

module mac_seq_ctrl #(
    parameter int LANES = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LANES-1:0] a_empty,
    input  logic             b_empty,
    output logic [LANES-1:0] a_rden,
    output logic             b_rden,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             busy,
    output logic             done,
    output logic [15:0]      stall_cnt
);

    // Issued-count wide enough to hold DEPTH itself.
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] issued;
    logic          drain_cnt;
    logic          fifo_ready;
    logic          all_issued;
    logic          run_issue;
    logic          abort_hit;
    logic          start_acc;

    // All lanes plus the shared B FIFO must have data; reads are all-or-nothing.
    assign fifo_ready = ~(|a_empty) & ~b_empty;
    assign all_issued = (issued == DEPTH_C);
    assign abort_hit  = abort && (state != S_IDLE);
    assign start_acc  = (state == S_IDLE) && start;

    // An abort cycle never reads, so a cancelled job leaves no orphan operands.
    assign run_issue  = (state == S_RUN) && !all_issued && fifo_ready && !abort;

    assign a_rden     = {LANES{run_issue}};
    assign b_rden     = run_issue;

    // Next-state selection; abort from any non-IDLE state overrides the normal flow.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_RUN;
            S_RUN:   if (all_issued) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issued-operand counter: cleared in CLEAR, advanced on every lockstep read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued <= '0;
        end else if (state == S_CLEAR) begin
            issued <= '0;
        end else if (run_issue) begin
            issued <= issued + CW'(1);
        end
    end

    // Two-cycle DRAIN timer; idles at zero outside DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= 1'b0;
        end else if (state == S_DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    // Registered outputs, aligned to the state they describe.
    // mac_en trails the read strobe by one cycle to match FIFO read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            mac_en  <= run_issue;
            mac_clr <= (state_nxt == S_CLEAR) || abort_hit;
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_DONE);
        end
    end

`ifdef MAC_SEQ_CTRL_STALL_CNT_EN
    logic        run_stall;
    logic [15:0] stall_q;

    // A stall is a RUN cycle that still owes reads but cannot issue.
    assign run_stall = (state == S_RUN) && !all_issued && !fifo_ready;

    // Saturating stall counter, restarted when a new job is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (run_stall && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl. Cycle numbers are relative to the
// cycle in which start is first presented (cycle 0). A DEPTH=1 instance with a
// small FIFO/MAC model covers the single-issue case.

module tb_mac_seq_ctrl;

    localparam int LANES = 8;
    localparam int DEPTH = 8;
    localparam int L1    = 4;
`ifdef MAC_SEQ_CTRL_STALL_CNT_EN
    localparam int STALL_ON = 1;
`else
    localparam int STALL_ON = 0;
`endif
    localparam logic [7:0] A_VAL = 8'd3;
    localparam logic [7:0] B_VAL = 8'd5;

    typedef struct {
        int done_rel;
        int rd;
        int stall;
        int cout;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [LANES-1:0] a_empty;
    logic             b_empty;
    logic [LANES-1:0] a_rden;
    logic             b_rden;
    logic             mac_en;
    logic             mac_clr;
    logic             busy;
    logic             done;
    logic [15:0]      stall_cnt;

    logic             start1;
    logic             abort1;
    logic [L1-1:0]    a_empty1;
    logic             b_empty1;
    logic [L1-1:0]    a_rden1;
    logic             b_rden1;
    logic             mac_en1;
    logic             mac_clr1;
    logic             busy1;
    logic             done1;
    logic [15:0]      stall1;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int n_dones;
    int done_at[2];
    int rd_cnt, en_cnt, clr_cnt, partial, done_stall;
    logic log_clr[64], log_rd[64], log_en[64], log_busy[64], log_done[64];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.LANES(LANES), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_empty(a_empty), .b_empty(b_empty), .a_rden(a_rden), .b_rden(b_rden),
        .mac_en(mac_en), .mac_clr(mac_clr), .busy(busy), .done(done),
        .stall_cnt(stall_cnt)
    );

    mac_seq_ctrl #(.LANES(L1), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a_empty(a_empty1), .b_empty(b_empty1), .a_rden(a_rden1), .b_rden(b_rden1),
        .mac_en(mac_en1), .mac_clr(mac_clr1), .busy(busy1), .done(done1),
        .stall_cnt(stall1)
    );

    // FIFO (1-cycle read latency) plus MAC (multiply reg, accumulate reg) model.
    logic [7:0]  a_q1[L1];
    logic [7:0]  b_q1;
    logic [15:0] prod1[L1];
    logic [15:0] acc1[L1];
    logic        en_d1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q1  <= '0;
            en_d1 <= 1'b0;
            for (int l = 0; l < L1; l++) begin
                a_q1[l]  <= '0;
                prod1[l] <= '0;
                acc1[l]  <= '0;
            end
        end else begin
            if (b_rden1) b_q1 <= B_VAL;
            en_d1 <= mac_en1;
            for (int l = 0; l < L1; l++) begin
                if (a_rden1[l]) a_q1[l] <= A_VAL;
                if (mac_clr1) begin
                    prod1[l] <= '0;
                    acc1[l]  <= '0;
                end else begin
                    if (mac_en1) prod1[l] <= a_q1[l] * b_q1;
                    if (en_d1)   acc1[l]  <= acc1[l] + prod1[l];
                end
            end
        end
    end

    // Drives one job cycle by cycle and logs outputs; entered and left at posedge+1.
    task automatic run_job(input int max_cyc, input int want_dones, input bit hold_start,
                           input int stall_lane, input int stall_from, input int stall_len,
                           input int abort_at);
        int n;
        n = 0;
        n_dones = 0; done_at[0] = -1; done_at[1] = -1;
        rd_cnt = 0; en_cnt = 0; clr_cnt = 0; partial = 0; done_stall = -1;
        for (int i = 0; i < 64; i++) begin
            log_clr[i] = 1'b0; log_rd[i] = 1'b0; log_en[i] = 1'b0;
            log_busy[i] = 1'b0; log_done[i] = 1'b0;
        end
        while (n < max_cyc && n_dones < want_dones) begin
            start   = (n == 0) || hold_start;
            abort   = (n == abort_at);
            a_empty = '0;
            if (stall_lane >= 0 && n >= stall_from && n < stall_from + stall_len)
                a_empty = {{(LANES-1){1'b0}}, 1'b1} << stall_lane;
            @(negedge clk);
            if (n < 64) begin
                log_clr[n] = mac_clr; log_rd[n] = b_rden; log_en[n] = mac_en;
                log_busy[n] = busy;   log_done[n] = done;
            end
            if (b_rden)  rd_cnt++;
            if (mac_en)  en_cnt++;
            if (mac_clr) clr_cnt++;
            if (a_rden !== {LANES{b_rden}}) partial++;
            if (done) begin
                if (n_dones == 0) done_stall = int'(stall_cnt);
                if (n_dones < 2) done_at[n_dones] = n;
                n_dones++;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; abort = 1'b0; a_empty = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a_empty = '0; b_empty = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; a_empty1 = '0; b_empty1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_rden, b_rden, mac_en, mac_clr, busy, done, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rden=%h/%b en=%b clr=%b busy=%b done=%b stall=%0d, want all 0",
                     a_rden, b_rden, mac_en, mac_clr, busy, done, stall_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        exp_t e;
        bit ec, er, ee, ed, eb;
        sb.push_back('{done_rel: 13, rd: 8, stall: 0, cout: 0});
        run_job(40, 1, 1'b0, -1, 0, 0, -1);
        e = sb.pop_front();
        checks++;
        if (done_at[0] !== e.done_rel) begin
            errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_at[0], e.done_rel);
        end
        checks++;
        if (rd_cnt !== e.rd || en_cnt !== e.rd) begin
            errors++; $display("FAIL basic_counts: got rd=%0d en=%0d want %0d", rd_cnt, en_cnt, e.rd);
        end
        checks++;
        if (done_stall !== e.stall) begin
            errors++; $display("FAIL basic_stall: got %0d want %0d", done_stall, e.stall);
        end
        for (int n = 0; n <= 13; n++) begin
            ec = (n == 1); er = (n >= 2 && n <= 9); ee = (n >= 3 && n <= 10);
            ed = (n == 13); eb = (n >= 1 && n <= 13);
            checks++;
            if ({log_clr[n], log_rd[n], log_en[n], log_done[n], log_busy[n]} !== {ec, er, ee, ed, eb}) begin
                errors++;
                $display("FAIL basic_timing c%0d: got clr/rd/en/done/busy=%b%b%b%b%b want %b%b%b%b%b", n,
                         log_clr[n], log_rd[n], log_en[n], log_done[n], log_busy[n], ec, er, ee, ed, eb);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        sb.push_back('{done_rel: 16, rd: 8, stall: 3 * STALL_ON, cout: 0});
        run_job(40, 1, 1'b0, 3, 4, 3, -1);
        e = sb.pop_front();
        checks++;
        if (done_at[0] !== e.done_rel) begin
            errors++; $display("FAIL stall_done_cycle: got %0d want %0d", done_at[0], e.done_rel);
        end
        checks++;
        if (done_stall !== e.stall) begin
            errors++; $display("FAIL stall_count: got %0d want %0d", done_stall, e.stall);
        end
        checks++;
        if (partial !== 0 || rd_cnt !== e.rd) begin
            errors++; $display("FAIL stall_reads: got partial=%0d rd=%0d want 0/%0d", partial, rd_cnt, e.rd);
        end
        checks++;
        if ({log_rd[4], log_rd[5], log_rd[6], log_rd[7]} !== 4'b0001) begin
            errors++; $display("FAIL stall_window: got rd c4..7=%b%b%b%b want 0001",
                               log_rd[4], log_rd[5], log_rd[6], log_rd[7]);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        sb.push_back('{done_rel: -1, rd: 4, stall: 0, cout: 0});
        // FIFOs are also empty in the abort cycle, so no fifth read is possible either way.
        run_job(30, 1, 1'b0, 0, 6, 1, 6);
        e = sb.pop_front();
        checks++;
        if (done_at[0] !== e.done_rel) begin
            errors++; $display("FAIL abort_no_done: got done at %0d want none", done_at[0]);
        end
        checks++;
        if (rd_cnt !== e.rd || en_cnt !== e.rd) begin
            errors++; $display("FAIL abort_counts: got rd=%0d en=%0d want %0d", rd_cnt, en_cnt, e.rd);
        end
        checks++;
        if ({log_busy[6], log_clr[7], log_busy[7], log_clr[8]} !== 4'b1100) begin
            errors++; $display("FAIL abort_exit: got busy6/clr7/busy7/clr8=%b%b%b%b want 1100",
                               log_busy[6], log_clr[7], log_busy[7], log_clr[8]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{done_rel: 13, rd: 8, stall: 0, cout: 0});
        sb.push_back('{done_rel: 27, rd: 8, stall: 0, cout: 0});
        run_job(60, 2, 1'b1, -1, 0, 0, -1);
        e = sb.pop_front();
        checks++;
        if (done_at[0] !== e.done_rel) begin
            errors++; $display("FAIL b2b_first_done: got %0d want %0d", done_at[0], e.done_rel);
        end
        e = sb.pop_front();
        checks++;
        if (done_at[1] !== e.done_rel) begin
            errors++; $display("FAIL b2b_second_done: got %0d want %0d", done_at[1], e.done_rel);
        end
        checks++;
        if (rd_cnt !== 2 * e.rd || clr_cnt !== 2) begin
            errors++; $display("FAIL b2b_counts: got rd=%0d clr=%0d want %0d/2", rd_cnt, clr_cnt, 2 * e.rd);
        end
        checks++;
        if ({log_busy[14], log_clr[14], log_clr[15]} !== 3'b001) begin
            errors++; $display("FAIL b2b_idle_visit: got busy14/clr14/clr15=%b%b%b want 001",
                               log_busy[14], log_clr[14], log_clr[15]);
        end
    endtask

    task automatic test_reset_mid_job();
        exp_t e;
        int stray;
        run_job(11, 1, 1'b0, -1, 0, 0, -1);
        checks++;
        if (n_dones !== 0 || log_busy[10] !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got dones=%0d busy10=%b want 0/1", n_dones, log_busy[10]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_rden, b_rden, mac_en, mac_clr, busy, done, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_async: got rden=%h en=%b clr=%b busy=%b done=%b stall=%0d want all 0",
                     a_rden, mac_en, mac_clr, busy, done, stall_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b_rden || (|a_rden) || busy || done || mac_en) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", stray);
        end
        @(posedge clk); #1;
        sb.push_back('{done_rel: DEPTH + 5, rd: 8, stall: 0, cout: 0});
        run_job(40, 1, 1'b0, -1, 0, 0, -1);
        e = sb.pop_front();
        checks++;
        if (done_at[0] !== e.done_rel || rd_cnt !== e.rd) begin
            errors++; $display("FAIL rst_rerun: got done=%0d rd=%0d want %0d/%0d",
                               done_at[0], rd_cnt, e.done_rel, e.rd);
        end
    endtask

    task automatic test_depth1();
        exp_t e;
        int got_at, rd1;
        sb.push_back('{done_rel: 6, rd: 1, stall: 0, cout: int'(A_VAL) * int'(B_VAL)});
        got_at = -1; rd1 = 0;
        start1 = 1'b1;
        for (int n = 0; n < 30 && got_at < 0; n++) begin
            @(negedge clk);
            if (b_rden1) rd1++;
            if (a_rden1 !== {L1{b_rden1}}) rd1 += 100;
            if (done1) begin
                got_at = n;
                e = sb.pop_front();
                checks++;
                if (n !== e.done_rel || rd1 !== e.rd || busy1 !== 1'b1 || stall1 !== 16'd0) begin
                    errors++; $display("FAIL d1_done: got cycle=%0d rd=%0d busy=%b stall=%0d want %0d/%0d/1/0",
                                       n, rd1, busy1, stall1, e.done_rel, e.rd);
                end
                for (int l = 0; l < L1; l++) begin
                    checks++;
                    if (int'(acc1[l]) !== e.cout) begin
                        errors++; $display("FAIL d1_cout lane%0d: got %0d want %0d", l, acc1[l], e.cout);
                    end
                end
            end
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        checks++;
        if (got_at < 0) begin
            errors++; $display("FAIL d1_timeout: no done within 30 cycles");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid_job();
        test_depth1();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
